ex_mdu: RTL and testbench

EX_MDU -- requirements
Module: ex_mdu

---
 rtl/ex_mdu_pkg.sv | 29 ++
 rtl/ex_mdu_md_core.sv | 44 ++++
 rtl/ex_mdu.sv | 157 +++++++++++++++
 tb/tb_ex_mdu.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared CPU definitions for the multiply/divide unit: op encodings,
// default latencies and the FSM state type.
package ex_mdu_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   // Counter must hold the larger latency without wrapping.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/ex_mdu_md_core.sv
// Combinational 32x32 arithmetic for the MDU: signed/unsigned 64-bit
// products and signed/unsigned quotient/remainder.
module md_core (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] prod_s,
   output logic [63:0] prod_u,
   output logic [31:0] quot_s,
   output logic [31:0] rem_s,
   output logic [31:0] quot_u,
   output logic [31:0] rem_u,
   output logic        div_zero
);

   logic signed [63:0] a_ext;
   logic signed [63:0] b_ext;
   logic signed [63:0] prod_sgn;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;

   assign a_ext    = {{32{a[31]}}, a};
   assign b_ext    = {{32{b[31]}}, b};
   assign prod_sgn = a_ext * b_ext;
   assign prod_s   = prod_sgn;
   assign prod_u   = {32'd0, a} * {32'd0, b};

   assign div_zero = (b == 32'd0);

   // Signed divide works on magnitudes; 0x80000000 is its own magnitude as
   // an unsigned value, so MIN/-1 wraps back to 0x80000000 with remainder 0.
   assign a_mag = a[31] ? (~a + 32'd1) : a;
   assign b_mag = b[31] ? (~b + 32'd1) : b;
   assign q_mag = div_zero ? 32'd0 : (a_mag / b_mag);
   assign r_mag = div_zero ? 32'd0 : (a_mag % b_mag);

   assign quot_s = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
   assign rem_s  = a[31] ? (~r_mag + 32'd1) : r_mag;

   assign quot_u = div_zero ? 32'd0 : (a / b);
   assign rem_u  = div_zero ? 32'd0 : (a % b);

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: multi-cycle MULT/DIV with HI/LO commit at
// the end of RUN, single-cycle MTHI/MTLO, combinational MFHI/MFLO read.
module ex_mdu
   import ex_mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        cancel,
   input  logic        mf_sel,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mf_out
);

   localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

   mdu_state_e         state;
   logic [CNT_W-1:0]   cnt;
   logic [31:0]        pend_hi;
   logic [31:0]        pend_lo;
   logic               pend_wr;

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] quot_s;
   logic [31:0] rem_s;
   logic [31:0] quot_u;
   logic [31:0] rem_u;
   logic        div_zero;

   logic             issue;
   logic             run_op;
   logic             mt_hi;
   logic             mt_lo;
   logic             res_wr;
   logic [31:0]      res_hi;
   logic [31:0]      res_lo;
   logic [CNT_W-1:0] run_len;

   md_core u_md_core (
      .a        (rs_data),
      .b        (rt_data),
      .prod_s   (prod_s),
      .prod_u   (prod_u),
      .quot_s   (quot_s),
      .rem_s    (rem_s),
      .quot_u   (quot_u),
      .rem_u    (rem_u),
      .div_zero (div_zero)
   );

   assign issue  = start & ~cancel & ~busy;
   assign mf_out = mf_sel ? hi : lo;

   always_comb begin
      res_hi  = 32'd0;
      res_lo  = 32'd0;
      res_wr  = 1'b0;
      run_op  = 1'b0;
      mt_hi   = 1'b0;
      mt_lo   = 1'b0;
      run_len = '0;
      case (md_op)
         MD_MULT: begin
            res_hi  = prod_s[63:32];
            res_lo  = prod_s[31:0];
            res_wr  = 1'b1;
            run_op  = 1'b1;
            run_len = CNT_W'(MULT_CYCLES);
         end
         MD_MULTU: begin
            res_hi  = prod_u[63:32];
            res_lo  = prod_u[31:0];
            res_wr  = 1'b1;
            run_op  = 1'b1;
            run_len = CNT_W'(MULT_CYCLES);
         end
         // A zero divisor still occupies the full latency but never commits.
         MD_DIV: begin
            res_hi  = rem_s;
            res_lo  = quot_s;
            res_wr  = ~div_zero;
            run_op  = 1'b1;
            run_len = CNT_W'(DIV_CYCLES);
         end
         MD_DIVU: begin
            res_hi  = rem_u;
            res_lo  = quot_u;
            res_wr  = ~div_zero;
            run_op  = 1'b1;
            run_len = CNT_W'(DIV_CYCLES);
         end
         MD_MTHI: mt_hi = 1'b1;
         MD_MTLO: mt_lo = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         cnt     <= '0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (issue) begin
                  if (run_op) begin
                     pend_hi <= res_hi;
                     pend_lo <= res_lo;
                     pend_wr <= res_wr;
                     cnt     <= run_len;
                     state   <= ST_RUN;
                     busy    <= 1'b1;
                  end else if (mt_hi) begin
                     hi <= rs_data;
                  end else if (mt_lo) begin
                     lo <= rs_data;
                  end
               end
            end
            // cnt==1 marks the last RUN cycle; commit on the edge that ends it.
            ST_RUN: begin
               if (cnt == CNT_W'(1)) begin
                  if (pend_wr) begin
                     hi <= pend_hi;
                     lo <= pend_lo;
                  end
                  cnt   <= '0;
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: expected HI/LO queued at issue, popped when busy falls.
module tb_ex_mdu;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  md_op = 3'd0;
   logic [31:0] rs_data = 32'd0;
   logic [31:0] rt_data = 32'd0;
   logic        cancel = 1'b0;
   logic        mf_sel = 1'b0;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mf_out;

   int checks = 0;
   int errors = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [63:0] exp_q[$];

   ex_mdu dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .md_op   (md_op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .cancel  (cancel),
      .mf_sel  (mf_sel),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo),
      .mf_out  (mf_out)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] cur);
      longint sa, sb;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         3'd0: return 64'(sa * sb);
         3'd1: return ua * ub;
         3'd2: if (b == 32'd0) return cur; else return {32'(sa % sb), 32'(sa / sb)};
         3'd3: if (b == 32'd0) return cur; else return {32'(ua % ub), 32'(ua / ub)};
         default: return cur;
      endcase
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic c);
      @(negedge clk);
      start = 1'b1; md_op = op; rs_data = a; rt_data = b; cancel = c;
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0;
   endtask

   task automatic wait_run(input int ncyc, input int n0, input string name);
      int n;
      logic [63:0] ex;
      n = n0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         checks++;
         if ({hi, lo} !== {m_hi, m_lo}) begin
            errors++;
            $display("FAIL %s_hold: hi/lo=%h/%h expected %h/%h", name, hi, lo, m_hi, m_lo);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (n !== ncyc) begin
         errors++;
         $display("FAIL %s_busy_len: got %0d expected %0d", name, n, ncyc);
      end
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s_queue: scoreboard empty", name);
      end else begin
         ex = exp_q.pop_front();
         m_hi = ex[63:32];
         m_lo = ex[31:0];
         checks++;
         if (hi !== m_hi) begin
            errors++;
            $display("FAIL %s_hi: got %h expected %h", name, hi, m_hi);
         end
         checks++;
         if (lo !== m_lo) begin
            errors++;
            $display("FAIL %s_lo: got %h expected %h", name, lo, m_lo);
         end
      end
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int ncyc, input string name);
      exp_q.push_back(model(op, a, b, {m_hi, m_lo}));
      issue(op, a, b, 1'b0);
      wait_run(ncyc, 0, name);
   endtask

   task automatic mt(input logic [2:0] op, input logic [31:0] v, input logic c, input string name);
      issue(op, v, 32'd0, c);
      if (!c && op == 3'd4) m_hi = v;
      if (!c && op == 3'd5) m_lo = v;
      checks++;
      if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s: hi/lo/busy=%h/%h/%b expected %h/%h/0", name, hi, lo, busy, m_hi, m_lo);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || mf_out !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: busy/hi/lo/mf=%b/%h/%h/%h expected 0", busy, hi, lo, mf_out);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_move;
      mt(3'd4, 32'h0000_0011, 1'b0, "mthi");
      mt(3'd5, 32'h0000_0022, 1'b0, "mtlo");
      mf_sel = 1'b1; #1;
      checks++;
      if (mf_out !== m_hi) begin
         errors++;
         $display("FAIL mfhi: got %h expected %h", mf_out, m_hi);
      end
      mf_sel = 1'b0; #1;
      checks++;
      if (mf_out !== m_lo) begin
         errors++;
         $display("FAIL mflo: got %h expected %h", mf_out, m_lo);
      end
   endtask

   task automatic test_div_zero;
      run_op(3'd2, 32'd5, 32'd0, DIV_N, "div_zero");
      run_op(3'd3, 32'd9, 32'd0, DIV_N, "divu_zero");
   endtask

   task automatic test_mult;
      run_op(3'd0, 32'hFFFF_FFFE, 32'd3, MULT_N, "mult_neg");
      checks++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
         errors++;
         $display("FAIL mult_const: got %h/%h expected ffffffff/fffffffa", hi, lo);
      end
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_N, "multu_max");
      run_op(3'd0, 32'h8000_0000, 32'h8000_0000, MULT_N, "mult_min");
      for (int i = 0; i < 4; i++) begin
         run_op(3'(i % 2), $urandom, $urandom, MULT_N, "mult_rand");
      end
   endtask

   task automatic test_div;
      run_op(3'd3, 32'd100, 32'd7, DIV_N, "divu");
      checks++;
      if (lo !== 32'd14 || hi !== 32'd2) begin
         errors++;
         $display("FAIL divu_const: got hi/lo %h/%h expected 2/14", hi, lo);
      end
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, DIV_N, "div_neg");
      checks++;
      if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL div_neg_const: got hi/lo %h/%h expected ffffffff/fffffffd", hi, lo);
      end
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, "div_ovf");
      checks++;
      if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
         errors++;
         $display("FAIL div_ovf_const: got hi/lo %h/%h expected 0/80000000", hi, lo);
      end
      run_op(3'd2, 32'd7, 32'hFFFF_FFFE, DIV_N, "div_pos_neg");
      for (int i = 0; i < 4; i++) begin
         run_op(3'(2 + (i % 2)), $urandom, $urandom_range(1, 70000), DIV_N, "div_rand");
      end
   endtask

   task automatic test_cancel;
      issue(3'd0, 32'd3, 32'd4, 1'b1);
      checks++;
      if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
         errors++;
         $display("FAIL cancel_mult: busy/hi/lo=%b/%h/%h expected 0/%h/%h", busy, hi, lo, m_hi, m_lo);
      end
      repeat (MULT_N + 1) @(posedge clk);
      #1;
      checks++;
      if (hi !== m_hi || lo !== m_lo) begin
         errors++;
         $display("FAIL cancel_mult_late: hi/lo=%h/%h expected %h/%h", hi, lo, m_hi, m_lo);
      end
      mt(3'd5, 32'hDEAD_BEEF, 1'b1, "cancel_mtlo");
      mt(3'd6, 32'h1234_5678, 1'b0, "reserved_op");
   endtask

   task automatic test_back_to_back;
      exp_q.push_back(model(3'd3, 32'd1000, 32'd33, {m_hi, m_lo}));
      issue(3'd3, 32'd1000, 32'd33, 1'b0);
      @(negedge clk);
      start = 1'b1; md_op = 3'd1; rs_data = 32'h0001_0000; rt_data = 32'h0001_0000;
      @(posedge clk); #1;
      start = 1'b0;
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      wait_run(DIV_N, 2, "b2b_div");
      mt(3'd4, 32'h0000_ABCD, 1'b0, "b2b_mthi");
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || hi !== 32'h0000_ABCD) begin
         errors++;
         $display("FAIL b2b_no_second: busy/hi=%b/%h expected 0/0000abcd", busy, hi);
      end
   endtask

   task automatic test_reset_mid_run;
      mt(3'd5, 32'h5555_AAAA, 1'b0, "pre_reset_mtlo");
      issue(3'd0, 32'h1234, 32'h5678, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      m_hi = 32'd0;
      m_lo = 32'd0;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++;
         $display("FAIL async_reset: busy/hi/lo=%b/%h/%h expected 0/0/0", busy, hi, lo);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (MULT_N + 3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         errors++;
         $display("FAIL reset_no_commit: busy/hi/lo=%b/%h/%h expected 0/0/0", busy, hi, lo);
      end
      run_op(3'd0, 32'd6, 32'd7, MULT_N, "post_reset_mult");
   endtask

   initial begin
      test_reset();
      test_move();
      test_div_zero();
      test_mult();
      test_div();
      test_cancel();
      test_back_to_back();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
